nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
//
// PURPOSE
// Sequencing controller that adds two wide operands by reusing one 4-bit ripple-carry adder for NIBBLES cycles.
// Processes one nibble per clock, LSB first, and registers the inter-nibble carry.
// Sits between a requester (start/done handshake) and the shared 4-bit adder datapath.
// Trades latency for area on wide additions.
//
// PARAMETERS
// NIBBLES  4  operand width in nibbles (operand width W = 4*NIBBLES); legal range 1..16
//
// PORTS
// clk        in   1   single clock, rising edge
// reset      in   1   asynchronous, active-high; clears all state
// start      in   1   request; sampled on clk edge when state is IDLE or DONE
// a          in   W   operand A; latched when start is accepted
// b          in   W   operand B; latched when start is accepted
// carry_in   in   1   initial carry; latched when start is accepted
// busy       out  1   1 while state is RUN
// done       out  1   one-cycle pulse: sum/carry_out are valid
// sum        out  W   result; held until the next completion
// carry_out  out  1   carry out of the MS nibble; held with sum
//
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, done=0, sum=0, carry_out=0; nibble index=0; carry reg=0; operand regs=0.
// - Reset mid-RUN aborts immediately; no done pulse; outputs go to 0.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE --start--> RUN
//   - RUN --(idx==NIBBLES-1)--> DONE
//   - DONE --start--> RUN (back-to-back operation)
//   - DONE --!start--> IDLE
// - Accept edge E0 (start=1 in IDLE/DONE): latch a, b and carry_in; idx=0; state=RUN.
// - Edges E1..EN (RUN): the adder sees a[4i+3:4i], b[4i+3:4i] and the carry reg, where i=idx.
//   - Nibble i of the internal accumulator is written; carry reg <= adder carry; idx++.
// - Edge EN: the full accumulator and the final carry are copied to sum and carry_out; state=DONE.
//   - done=1 for exactly the cycle after EN; latency is NIBBLES clocks from the accept edge.
// - start while RUN is ignored: no latch, no queueing, in-flight op is unaffected.
// - sum/carry_out change only at EN; never show partial results.
// - Arithmetic: {carry_out,sum} = a + b + carry_in, modulo 2^(W+1); no truncation.
// - NIBBLES=1: RUN lasts one cycle; done follows the accept edge by one clock.
// - idx is sized clog2(NIBBLES) (min 1 bit) and resets to 0 on every accept.
//
// CONFIGURATION
// SUBTRACT_EN (define):
//   - Adds input port sub (1 bit), latched on accept.
//   - When sub=1: the latched b is inverted and the initial carry is forced to 1; carry_in is ignored.
//     - Result is a - b; carry_out=1 means no borrow.
//   - When sub=0: identical to the undefined build.
// SUBTRACT_EN undefined: no sub port; add only.
//
// TESTING (NIBBLES=4 unless noted)
// 1. a=16'hFFFF, b=16'h0001, carry_in=0, start at E0 -> done cycle after E4; sum=16'h0000, carry_out=1.
// 2. a=16'h1234, b=16'h4321, carry_in=1 -> sum=16'h5556, carry_out=0; busy=1 for 4 cycles.
// 3. start=1 held through RUN with new operands -> ignored; first result unchanged.
//    start in the DONE cycle -> new op starts with no IDLE gap.
// 4. reset asserted at E2 of an op (async, mid-cycle) -> outputs 0 and state IDLE at once.
//    No done pulse; the next op is correct.
// 5. NIBBLES=1: a=4'h9, b=4'h8, carry_in=1 -> sum=4'h2, carry_out=1, done 1 clock after accept.
// 6. SUBTRACT_EN, sub=1: a=16'h0005, b=16'h0007 -> sum=16'hFFFE, carry_out=0.
//    a=16'h0007, b=16'h0005 -> sum=16'h0002, carry_out=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// Adds two W-bit operands (W = 4*NIBBLES) by reusing a single 4-bit
// ripple-carry adder, one nibble per clock, least significant nibble first.
// The carry between nibbles is kept in a register. The requester starts an
// operation with start. It receives a one-cycle done pulse when sum and
// carry_out hold the new result.
//
// Parameters:
//   NIBBLES    operand width in nibbles, 1..16
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   start      request; accepted only in IDLE or DONE
//   a, b       W-bit operands, latched on accept
//   carry_in   initial carry, latched on accept
//   sub        (only with SUBTRACT_EN) 1 = compute a - b, latched on accept
//   busy       1 while the nibble loop runs
//   done       one-cycle pulse; sum/carry_out valid
//   sum        W-bit result, held until the next completion
//   carry_out  carry out of the top nibble, held with sum
//
// Build option: define SUBTRACT_EN to add the sub port. With sub=1 the
// latched b is inverted and the initial carry is forced to 1. A carry_out
// of 1 then means no borrow.

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   carry_in,
`ifdef SUBTRACT_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   carry_out
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg;
    logic            carry_reg;
    logic [W-1:0]    a_reg, b_reg;
    logic [W-1:0]    acc_reg, acc_next;
    logic [W-1:0]    sum_reg;
    logic            carry_out_reg;
    logic            accept;

    logic [NIBBLES-1:0] nib_hit;
    logic [3:0]         a_nib, b_nib;
    logic [4:0]         add_res;

    // Operand values as they are registered on an accepted start.
    logic [W-1:0] b_load;
    logic         carry_load;

`ifdef SUBTRACT_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : carry_in;
`else
    assign b_load     = b;
    assign carry_load = carry_in;
`endif

    // One-hot decode of the nibble index. The adder inputs and the
    // accumulator write-back are steered by this decode.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign nib_hit[gi] = (idx_reg == IW'(gi));
            assign acc_next[4*gi +: 4] = nib_hit[gi] ? add_res[3:0]
                                                     : acc_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (nib_hit[i]) begin
                a_nib = a_reg[4*i +: 4];
                b_nib = b_reg[4*i +: 4];
            end
        end
    end

    // The shared 4-bit adder.
    assign add_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_reg};

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b_load;
                carry_reg <= carry_load;
                idx_reg   <= '0;
            end else if (state_reg == RUN) begin
                acc_reg   <= acc_next;
                carry_reg <= add_res[4];
                if (idx_reg == LAST_IDX) begin
                    // acc_next already contains the top nibble. Publish the
                    // whole result at once, so partial sums are never visible.
                    sum_reg       <= acc_next;
                    carry_out_reg <= add_res[4];
                end else begin
                    idx_reg <= idx_reg + IW'(1);
                end
            end
        end
    end

    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl: one NIBBLES=4 instance and one
// NIBBLES=1 instance. Expected results come from plain wide arithmetic.

module tb_nibble_serial_adder_ctrl;

    localparam int N  = 4;
    localparam int W  = 4 * N;
`ifdef SUBTRACT_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         busy, done, carry_out;
    logic [W-1:0] sum;

    logic         start1 = 1'b0;
    logic [3:0]   a1 = '0;
    logic [3:0]   b1 = '0;
    logic         cin1 = 1'b0;
    logic         busy1, done1, cout1;
    logic [3:0]   sum1;

`ifdef SUBTRACT_EN
    logic sub  = 1'b0;
    logic sub1 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [W:0] held  = '0;
    logic [4:0] held1 = '0;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .carry_in(carry_in),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
        .carry_in(cin1),
`ifdef SUBTRACT_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {carry_out, sum} as plain (W+1)-bit arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
        logic [W:0] r;
        if (ms) r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
        else    r = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        return r;
    endfunction

    // Called at a falling edge. The call returns at the falling edge inside
    // the done cycle. hold keeps start high through RUN and scrambles the inputs.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc, input logic ts, input bit hold);
        logic [W:0] exp;
        exp = model(ta, tb_v, tc, ts);
        a = ta; b = tb_v; carry_in = tc;
`ifdef SUBTRACT_EN
        sub = ts;
`endif
        start = 1'b1;
        @(negedge clk);
        if (hold) begin
            a = W'($urandom); b = W'($urandom); carry_in = ~tc;
`ifdef SUBTRACT_EN
            sub = ~ts;
`endif
        end else begin
            start = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("sum_held", {carry_out, sum}, held);
            @(negedge clk);
        end
        start = 1'b0;
        check("done", done, 1);
        check("busy_done", busy, 0);
        check("result", {carry_out, sum}, exp);
        held = exp;
        $display("op a=%h b=%h cin=%0d sub=%0d hold=%0d -> cout=%0d sum=%h",
                 ta, tb_v, tc, ts, hold, carry_out, sum);
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("busy_idle", busy, 0);
        check("sum_idle", {carry_out, sum}, held);
    endtask

    task automatic op1(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
        logic [4:0] exp;
        exp = {1'b0, ta} + {1'b0, tb_v} + {4'b0000, tc};
        a1 = ta; b1 = tb_v; cin1 = tc; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("n1_busy", busy1, 1);
        check("n1_done_run", done1, 0);
        check("n1_sum_held", {cout1, sum1}, held1);
        @(negedge clk);
        check("n1_done", done1, 1);
        check("n1_result", {cout1, sum1}, exp);
        held1 = exp;
        $display("op1 a=%h b=%h cin=%0d -> cout=%0d sum=%h", ta, tb_v, tc, cout1, sum1);
        @(negedge clk);
        check("n1_done_end", done1, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", {carry_out, sum}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy0", busy, 0);
        check("idle_done0", done, 0);

        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        idle_check();
        op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
        idle_check();

        // start held through RUN, then a back-to-back op from DONE.
        op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
        op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
        idle_check();

        // Async reset between E2 and E3 aborts the op.
        a = 16'hABCD; b = 16'h1111; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", {carry_out, sum}, 0);
        held = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N + 1; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
        end
        op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
        idle_check();

`ifdef SUBTRACT_EN
        op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
        idle_check();
`endif

        for (int k = 0; k < 20; k++) begin
            op(W'($urandom), W'($urandom), 1'($urandom),
               SUB_ON ? 1'($urandom) : 1'b0, ($urandom % 3) == 0);
            if ($urandom % 2) idle_check();
        end
        idle_check();

        held1 = '0;
        op1(4'h9, 4'h8, 1'b1);
        for (int k = 0; k < 6; k++) begin
            op1(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
